riscv_imem_pair_arbiter: RTL and testbench

Merges the dual-issue core's two instruction-memory request/response port pairs (`imemreq0`/`imemresp0`, `imemreq1`/`imemresp1`) onto a single in-order memory port. It sits directly downstream of `riscv_Core` and in front of the single-ported instruction memory or cache.

- Requests are serialized, port 0 first.
- Issue order is tracked in a tag FIFO.
- Each memory response is steered back to the port that issued it.

---
 rtl/riscv_imem_pair_arbiter.sv | 149 ++++++++++++++
 tb/tb_riscv_imem_pair_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_imem_pair_arbiter.sv
// riscv_imem_pair_arbiter
//
// Merges the dual-issue core's two instruction-memory ports onto one in-order
// memory port. Both requester ports are accepted together into holding slots
// H0/H1. The slots are issued to memory one at a time, H0 first. A tag FIFO
// records which port each issued request came from, and each in-order memory
// response is steered back to that port one cycle after it arrives.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   imemreqN_msg/val/rdy            request from core port N (N = 0, 1)
//   imemrespN_msg/val               registered response to core port N
//   memreq_msg/val/rdy              request to memory, driven from H0/H1
//   memresp_msg/val                 memory response (always accepted)
//   outstanding                     issued, unanswered request count
//   error                           sticky: response with nothing outstanding
module riscv_imem_pair_arbiter #(
  parameter int unsigned p_max_outstanding = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,

  input  logic [66:0]                           imemreq0_msg,
  input  logic                                  imemreq0_val,
  output logic                                  imemreq0_rdy,
  output logic [34:0]                           imemresp0_msg,
  output logic                                  imemresp0_val,

  input  logic [66:0]                           imemreq1_msg,
  input  logic                                  imemreq1_val,
  output logic                                  imemreq1_rdy,
  output logic [34:0]                           imemresp1_msg,
  output logic                                  imemresp1_val,

  output logic [66:0]                           memreq_msg,
  output logic                                  memreq_val,
  input  logic                                  memreq_rdy,
  input  logic [34:0]                           memresp_msg,
  input  logic                                  memresp_val,

  output logic [$clog2(p_max_outstanding):0]    outstanding,
  output logic                                  error
);

  localparam int unsigned PtrW = $clog2(p_max_outstanding);
  localparam int unsigned CntW = PtrW + 1;
  // Accept only while two FIFO entries are free, so a full pair always fits.
  localparam logic [CntW-1:0] AcceptLimit = CntW'(p_max_outstanding - 2);

  logic [66:0]                  h0_msg_q, h0_msg_d, h1_msg_q, h1_msg_d;
  logic                         h0_v_q, h0_v_d, h1_v_q, h1_v_d;
  logic [p_max_outstanding-1:0] tag_mem_q, tag_mem_d;
  logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]              outstanding_q, outstanding_d;
  logic                         error_q, error_d;
  logic [34:0]                  resp0_msg_q, resp0_msg_d, resp1_msg_q, resp1_msg_d;
  logic                         resp0_val_q, resp0_val_d, resp1_val_q, resp1_val_d;

  logic req_rdy, fire, issue_tag, resp_ok, resp_tag;

  always_comb begin
    req_rdy   = !h0_v_q && !h1_v_q && (outstanding_q <= AcceptLimit);
    fire      = (h0_v_q || h1_v_q) && memreq_rdy;
    issue_tag = !h0_v_q;  // 0 = H0, 1 = H1
    resp_ok   = memresp_val && (outstanding_q != '0);
    resp_tag  = tag_mem_q[rd_ptr_q];

    h0_v_d   = h0_v_q;
    h1_v_d   = h1_v_q;
    h0_msg_d = h0_msg_q;
    h1_msg_d = h1_msg_q;
    // Accept and issue are mutually exclusive: accept needs both slots empty.
    if (req_rdy) begin
      h0_v_d = imemreq0_val;
      h1_v_d = imemreq1_val;
      if (imemreq0_val) h0_msg_d = imemreq0_msg;
      if (imemreq1_val) h1_msg_d = imemreq1_msg;
    end else if (fire) begin
      if (h0_v_q) h0_v_d = 1'b0;
      else        h1_v_d = 1'b0;
    end

    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (fire) begin
      tag_mem_d[wr_ptr_q] = issue_tag;
      wr_ptr_d            = wr_ptr_q + PtrW'(1);
    end
    if (resp_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({fire, resp_ok})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    error_d = error_q || (memresp_val && (outstanding_q == '0));

    resp0_val_d = resp_ok && !resp_tag;
    resp1_val_d = resp_ok && resp_tag;
    resp0_msg_d = resp0_val_d ? memresp_msg : resp0_msg_q;
    resp1_msg_d = resp1_val_d ? memresp_msg : resp1_msg_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h0_msg_q      <= '0;
      h1_msg_q      <= '0;
      h0_v_q        <= 1'b0;
      h1_v_q        <= 1'b0;
      tag_mem_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
      resp0_msg_q   <= '0;
      resp1_msg_q   <= '0;
      resp0_val_q   <= 1'b0;
      resp1_val_q   <= 1'b0;
    end else begin
      h0_msg_q      <= h0_msg_d;
      h1_msg_q      <= h1_msg_d;
      h0_v_q        <= h0_v_d;
      h1_v_q        <= h1_v_d;
      tag_mem_q     <= tag_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
      resp0_msg_q   <= resp0_msg_d;
      resp1_msg_q   <= resp1_msg_d;
      resp0_val_q   <= resp0_val_d;
      resp1_val_q   <= resp1_val_d;
    end
  end

  assign imemreq0_rdy  = req_rdy;
  assign imemreq1_rdy  = req_rdy;
  assign memreq_val    = h0_v_q || h1_v_q;
  assign memreq_msg    = h0_v_q ? h0_msg_q : h1_msg_q;
  assign imemresp0_msg = resp0_msg_q;
  assign imemresp0_val = resp0_val_q;
  assign imemresp1_msg = resp1_msg_q;
  assign imemresp1_val = resp1_val_q;
  assign outstanding   = outstanding_q;
  assign error         = error_q;

endmodule

// File: tb/tb_riscv_imem_pair_arbiter.sv
// Directed bench for riscv_imem_pair_arbiter (p_max_outstanding = 4).
// Inputs change and outputs are checked on the falling clock edge.
module tb_riscv_imem_pair_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [66:0] imemreq0_msg, imemreq1_msg, memreq_msg;
  logic        imemreq0_val, imemreq1_val, imemreq0_rdy, imemreq1_rdy;
  logic [34:0] imemresp0_msg, imemresp1_msg, memresp_msg;
  logic        imemresp0_val, imemresp1_val;
  logic        memreq_val, memreq_rdy, memresp_val;
  logic [2:0]  outstanding;
  logic        error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_imem_pair_arbiter #(.p_max_outstanding(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .imemreq0_msg  (imemreq0_msg),
    .imemreq0_val  (imemreq0_val),
    .imemreq0_rdy  (imemreq0_rdy),
    .imemresp0_msg (imemresp0_msg),
    .imemresp0_val (imemresp0_val),
    .imemreq1_msg  (imemreq1_msg),
    .imemreq1_val  (imemreq1_val),
    .imemreq1_rdy  (imemreq1_rdy),
    .imemresp1_msg (imemresp1_msg),
    .imemresp1_val (imemresp1_val),
    .memreq_msg    (memreq_msg),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memresp_msg   (memresp_msg),
    .memresp_val   (memresp_val),
    .outstanding   (outstanding),
    .error         (error)
  );

  // Read request: type 0, addr, len 0, data 0.
  function automatic logic [66:0] rq(input logic [31:0] addr);
    return {1'b0, addr, 2'b00, 32'h0};
  endfunction

  function automatic logic [34:0] rs(input logic [31:0] data);
    return {1'b0, 2'b00, data};
  endfunction

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    imemreq0_msg = '0; imemreq1_msg = '0; imemreq0_val = 0; imemreq1_val = 0;
    memreq_rdy = 1'b1; memresp_msg = '0; memresp_val = 1'b0;
    neg(); neg();
    chk("rst_memreq_val", 67'(memreq_val), 67'(0));
    chk("rst_outstanding", 67'(outstanding), 67'(0));
    chk("rst_error", 67'(error), 67'(0));
    chk("rst_resp_vals", 67'({imemresp0_val, imemresp1_val}), 67'(0));
    reset = 1'b0;

    // Paired fetch
    neg();
    chk("pair_rdy", 67'({imemreq0_rdy, imemreq1_rdy}), 67'(2'b11));
    imemreq0_val = 1; imemreq0_msg = rq(32'h100);
    imemreq1_val = 1; imemreq1_msg = rq(32'h104);
    neg();
    imemreq0_val = 0; imemreq1_val = 0;
    chk("pair_req0_val", 67'(memreq_val), 67'(1));
    chk("pair_req0_msg", memreq_msg, rq(32'h100));
    chk("pair_rdy_low", 67'(imemreq0_rdy), 67'(0));
    neg();
    chk("pair_req1_msg", memreq_msg, rq(32'h104));
    chk("pair_out1", 67'(outstanding), 67'(1));
    neg();
    chk("pair_req_idle", 67'(memreq_val), 67'(0));
    chk("pair_out2", 67'(outstanding), 67'(2));
    chk("pair_rdy_back", 67'(imemreq1_rdy), 67'(1));
    memresp_val = 1; memresp_msg = rs(32'hAAAA0000);
    neg();
    chk("pair_resp0_vals", 67'({imemresp0_val, imemresp1_val}), 67'(2'b10));
    chk("pair_resp0_msg", 67'(imemresp0_msg), 67'(rs(32'hAAAA0000)));
    chk("pair_out_after1", 67'(outstanding), 67'(1));
    memresp_msg = rs(32'hBBBB0000);
    neg();
    chk("pair_resp1_vals", 67'({imemresp0_val, imemresp1_val}), 67'(2'b01));
    chk("pair_resp1_msg", 67'(imemresp1_msg), 67'(rs(32'hBBBB0000)));
    chk("pair_out_after2", 67'(outstanding), 67'(0));
    memresp_val = 0;
    neg();
    chk("pair_resp_done", 67'({imemresp0_val, imemresp1_val}), 67'(0));

    // Single port 1
    imemreq1_val = 1; imemreq1_msg = rq(32'h200);
    neg();
    imemreq1_val = 0;
    chk("single_req_msg", memreq_msg, rq(32'h200));
    chk("single_req_val", 67'(memreq_val), 67'(1));
    neg();
    chk("single_req_idle", 67'(memreq_val), 67'(0));
    chk("single_out1", 67'(outstanding), 67'(1));
    memresp_val = 1; memresp_msg = rs(32'hCCCC0000);
    neg();
    memresp_val = 0;
    chk("single_resp_vals", 67'({imemresp0_val, imemresp1_val}), 67'(2'b01));
    chk("single_resp_msg", 67'(imemresp1_msg), 67'(rs(32'hCCCC0000)));

    // Memory stall
    memreq_rdy = 0; imemreq0_val = 1; imemreq0_msg = rq(32'h100);
    neg();
    imemreq0_val = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_msg", memreq_msg, rq(32'h100));
      chk("stall_val", 67'(memreq_val), 67'(1));
      chk("stall_rdy", 67'(imemreq0_rdy), 67'(0));
      chk("stall_out", 67'(outstanding), 67'(0));
      if (i == 4) memreq_rdy = 1;
      neg();
    end
    chk("stall_issued_val", 67'(memreq_val), 67'(0));
    chk("stall_issued_out", 67'(outstanding), 67'(1));
    memresp_val = 1; memresp_msg = rs(32'h11110000);
    neg();
    memresp_val = 0;
    chk("stall_resp_vals", 67'({imemresp0_val, imemresp1_val}), 67'(2'b10));

    // Outstanding limit: two pairs, no responses
    imemreq0_val = 1; imemreq0_msg = rq(32'h300);
    imemreq1_val = 1; imemreq1_msg = rq(32'h304);
    neg();
    imemreq0_val = 0; imemreq1_val = 0;
    neg(); neg();
    chk("lim_out2", 67'(outstanding), 67'(2));
    chk("lim_rdy_at2", 67'(imemreq0_rdy), 67'(1));
    imemreq0_val = 1; imemreq0_msg = rq(32'h308);
    imemreq1_val = 1; imemreq1_msg = rq(32'h30C);
    neg();
    imemreq0_val = 0; imemreq1_val = 0;
    neg(); neg();
    chk("lim_out4", 67'(outstanding), 67'(4));
    chk("lim_rdy_at4", 67'(imemreq0_rdy), 67'(0));
    memresp_val = 1; memresp_msg = rs(32'h30000000);
    neg();
    chk("lim_out3", 67'(outstanding), 67'(3));
    chk("lim_rdy_at3", 67'(imemreq1_rdy), 67'(0));
    chk("lim_resp_a", 67'({imemresp0_val, imemresp1_val}), 67'(2'b10));
    memresp_msg = rs(32'h30400000);
    neg();
    memresp_val = 0;
    chk("lim_out2b", 67'(outstanding), 67'(2));
    chk("lim_rdy_back", 67'(imemreq0_rdy), 67'(1));
    chk("lim_resp_b", 67'({imemresp0_val, imemresp1_val}), 67'(2'b01));
    chk("lim_resp_b_msg", 67'(imemresp1_msg), 67'(rs(32'h30400000)));
    imemreq0_val = 1; imemreq0_msg = rq(32'h310);
    neg();
    imemreq0_val = 0;
    chk("both_pre_val", 67'(memreq_val), 67'(1));
    memresp_val = 1; memresp_msg = rs(32'h30800000);
    neg();
    chk("both_out_same", 67'(outstanding), 67'(2));
    chk("both_resp_c", 67'({imemresp0_val, imemresp1_val}), 67'(2'b10));
    chk("both_resp_c_msg", 67'(imemresp0_msg), 67'(rs(32'h30800000)));
    memresp_msg = rs(32'h30C00000);
    neg();
    chk("drain_out1", 67'(outstanding), 67'(1));
    chk("drain_resp_d", 67'({imemresp0_val, imemresp1_val}), 67'(2'b01));
    memresp_msg = rs(32'h31000000);
    neg();
    memresp_val = 0;
    chk("drain_out0", 67'(outstanding), 67'(0));
    chk("drain_resp_e", 67'({imemresp0_val, imemresp1_val}), 67'(2'b10));
    chk("drain_resp_e_msg", 67'(imemresp0_msg), 67'(rs(32'h31000000)));

    // Spurious response
    chk("spur_pre_err", 67'(error), 67'(0));
    memresp_val = 1; memresp_msg = rs(32'hDEAD0000);
    neg();
    memresp_val = 0;
    chk("spur_err", 67'(error), 67'(1));
    chk("spur_no_resp", 67'({imemresp0_val, imemresp1_val}), 67'(0));
    chk("spur_out", 67'(outstanding), 67'(0));
    neg(); neg();
    chk("spur_err_held", 67'(error), 67'(1));

    // Reset mid-stream: H0 issued, H1 still held
    imemreq0_val = 1; imemreq0_msg = rq(32'h400);
    imemreq1_val = 1; imemreq1_msg = rq(32'h404);
    neg();
    imemreq0_val = 0; imemreq1_val = 0;
    neg();
    chk("mid_out1", 67'(outstanding), 67'(1));
    reset = 1;
    #1;
    chk("mid_rst_memreq_val", 67'(memreq_val), 67'(0));
    chk("mid_rst_out", 67'(outstanding), 67'(0));
    chk("mid_rst_err", 67'(error), 67'(0));
    neg(); neg();
    reset = 0;
    neg();
    chk("mid_rdy", 67'({imemreq0_rdy, imemreq1_rdy}), 67'(2'b11));
    chk("mid_memreq_idle", 67'(memreq_val), 67'(0));
    memresp_val = 1; memresp_msg = rs(32'h40000000);
    neg();
    memresp_val = 0;
    chk("late_resp_err", 67'(error), 67'(1));
    chk("late_resp_vals", 67'({imemresp0_val, imemresp1_val}), 67'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
